// File: rtl/ede_pkg.sv
// ede_pkg: FSM states, filter geometry and triangular coefficients shared by the ede_ctrl slice.
package ede_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;
  localparam int TAPS = 15;
  localparam int CTR = 7;
  function automatic logic [15:0] coef(input int k);
    return k < 0 || k >= TAPS ? 16'd0 : k <= CTR ? 16'(k + 1) : 16'(TAPS - k);
  endfunction
endpackage

// File: rtl/ede_if.sv
// ede_if: sample-in / filtered-word-out handshake bundle of ede_ctrl.
interface ede_if #(parameter int DW = 10);
  logic iStart;
  logic [DW-1:0] iDEL;
  logic iDELValid;
  logic oDELReady;
  logic [15:0] oWF;
  logic oWFValid;
  logic iWFReady;
  logic oBusy;
  logic oDone;
  modport master(output iStart, iDEL, iDELValid, iWFReady, input oDELReady, oWF, oWFValid, oBusy, oDone);
  modport slave(input iStart, iDEL, iDELValid, iWFReady, output oDELReady, oWF, oWFValid, oBusy, oDone);
endinterface

// File: rtl/ede_buf.sv
// ede_buf: record buffer, one write port and one read port with registered (1-cycle) read data.
module ede_buf #(
  parameter int N_SAMPLES = 2400,
  parameter int DW = 10,
  parameter int AW = $clog2(N_SAMPLES)
) (
  input  logic clk,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [N_SAMPLES];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/ede_ctrl.sv
// ede_ctrl: loads a record, then emits a 15-tap triangular smoothing of it with edge replication.
// Define EDE_NORM_EN to output the accumulator divided by 64 instead of the raw sum.
module ede_ctrl import ede_pkg::*; #(
  parameter int N_SAMPLES = 2400,
  parameter int DW = 10
) (
  input logic clk,
  input logic reset,
  ede_if.slave bus
);
  localparam int AW = $clog2(N_SAMPLES);
  localparam logic [AW-1:0] LAST = AW'(N_SAMPLES - 1);
  state_t st;
  logic [AW-1:0] cnt, n, raddr;
  logic [3:0] c;
  logic [15:0] acc, acc_nxt, wf_nxt;
  logic [DW-1:0] rdata;
  logic we;
  int pos;
  assign we = st == LOAD && bus.iDELValid && bus.oDELReady;
  // read for tap c is issued in cycle c and its product lands in cycle c+1
  always_comb begin
    pos = int'(n) + int'(c) - CTR;
    raddr = pos < 0 ? '0 : pos > N_SAMPLES - 1 ? LAST : AW'(pos);
    acc_nxt = (c == 4'd1 ? 16'd0 : acc) + coef(int'(c) - 1) * 16'(rdata);
  end
`ifdef EDE_NORM_EN
  assign wf_nxt = 16'(acc_nxt[15:6]);
`else
  assign wf_nxt = acc_nxt;
`endif
  ede_buf #(.N_SAMPLES(N_SAMPLES), .DW(DW), .AW(AW)) u_buf (
    .clk(clk), .we(we), .waddr(cnt), .wdata(bus.iDEL), .raddr(raddr), .rdata(rdata)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= IDLE;
      cnt <= '0;
      n <= '0;
      c <= '0;
      acc <= '0;
      bus.oDELReady <= 1'b0;
      bus.oWF <= '0;
      bus.oWFValid <= 1'b0;
      bus.oBusy <= 1'b0;
      bus.oDone <= 1'b0;
    end else begin
      bus.oDone <= 1'b0;
      case (st)
        IDLE: if (bus.iStart) begin
          st <= LOAD;
          cnt <= '0;
          bus.oDELReady <= 1'b1;
          bus.oBusy <= 1'b1;
        end
        LOAD: if (we) begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            st <= CALC;
            n <= '0;
            c <= '0;
            bus.oDELReady <= 1'b0;
          end
        end
        CALC: begin
          c <= c + 4'd1;
          if (c != 4'd0) acc <= acc_nxt;
          if (c == 4'd15) begin
            st <= OUT;
            bus.oWF <= wf_nxt;
            bus.oWFValid <= 1'b1;
          end
        end
        OUT: if (bus.iWFReady) begin
          bus.oWFValid <= 1'b0;
          c <= '0;
          if (n == LAST) begin
            st <= IDLE;
            bus.oBusy <= 1'b0;
            bus.oDone <= 1'b1;
          end else begin
            st <= CALC;
            n <= n + 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ede_ctrl.sv
// tb_ede_ctrl: random-handshake records checked against a direct clamp-and-sum filter model.
module tb_ede_ctrl;
  localparam int N = 128;
  localparam int DW = 10;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  ede_if #(.DW(DW)) bus();
  ede_ctrl #(.N_SAMPLES(N), .DW(DW)) dut(.clk(clk), .reset(reset), .bus(bus));
  int checks = 0, passed = 0, dones = 0;
  logic [DW-1:0] x [N];
  int got [N];
  always @(negedge clk) if (bus.oDone) dones++;
  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask
  function automatic int nrm(input int v);
`ifdef EDE_NORM_EN
    return v / 64;
`else
    return v;
`endif
  endfunction
  function automatic int model(input int n);
    int s = 0;
    for (int k = 0; k < 15; k++) begin
      int j = n + k - 7;
      j = j < 0 ? 0 : j > N - 1 ? N - 1 : j;
      s += (k <= 7 ? k + 1 : 15 - k) * int'(x[j]);
    end
    return nrm(s);
  endfunction
  task automatic load();
    int i = 0, cyc = 0;
    bus.iStart = 1;
    bus.iDELValid = 1;
    bus.iDEL = '1;
    @(negedge clk);
    check("busy_on_start", bus.oBusy, 1);
    while (i < N && cyc < 20 * N) begin
      bus.iDEL = x[i];
      bus.iDELValid = $urandom_range(0, 3) != 0;
      bus.iStart = cyc == 7;
      if (bus.iDELValid && bus.oDELReady) i++;
      @(negedge clk);
      cyc++;
    end
    bus.iDELValid = 0;
    bus.iStart = 0;
    check("load_count", i, N);
    check("ready_low_after_load", bus.oDELReady, 0);
  endtask
  task automatic collect(input int abort_at);
    int d0 = dones, bad = 0;
    for (int n = 0; n < N; n++) begin
      int cyc = 0, r;
      logic [15:0] hold;
      while (!bus.oWFValid && cyc < 40) begin
        bus.iStart = n == 3 && cyc == 4;
        if (n == abort_at && cyc == 5) begin
          bus.iStart = 0;
          reset = 0;
          @(negedge clk);
          check("rst_busy", bus.oBusy, 0);
          check("rst_valid", bus.oWFValid, 0);
          check("rst_wf", bus.oWF, 0);
          check("rst_ready", bus.oDELReady, 0);
          reset = 1;
          return;
        end
        @(negedge clk);
        cyc++;
      end
      bus.iStart = 0;
      check($sformatf("calc_len[%0d]", n), cyc, 16);
      if (cyc != 16) return;
      hold = bus.oWF;
      r = n == 5 ? 20 : $urandom_range(0, 2);
      repeat (r) begin
        bus.iWFReady = 0;
        @(negedge clk);
        if (bus.oWFValid !== 1'b1 || bus.oWF !== hold) bad++;
      end
      got[n] = int'(bus.oWF);
      check($sformatf("wf[%0d]", n), got[n], model(n));
      bus.iWFReady = 1;
      @(negedge clk);
      bus.iWFReady = 0;
      if (n == N - 1) begin
        check("done_pulse", bus.oDone, 1);
        check("idle_busy", bus.oBusy, 0);
      end else begin
        check($sformatf("no_dup[%0d]", n), bus.oWFValid, 0);
      end
    end
    check("hold_stable", bad, 0);
    @(negedge clk);
    check("done_count", dones - d0, 1);
  endtask
  initial begin
    bus.iStart = 0;
    bus.iDEL = '0;
    bus.iDELValid = 0;
    bus.iWFReady = 0;
    #1 reset = 0;
    repeat (3) @(negedge clk);
    check("rst0_busy", bus.oBusy, 0);
    check("rst0_valid", bus.oWFValid, 0);
    check("rst0_ready", bus.oDELReady, 0);
    check("rst0_done", bus.oDone, 0);
    check("rst0_wf", bus.oWF, 0);
    reset = 1;
    @(negedge clk);
    for (int i = 0; i < N; i++) x[i] = 100;
    load();
    collect(-1);
    check("const_first", got[0], nrm(6400));
    check("const_last", got[N-1], nrm(6400));
    for (int i = 0; i < N; i++) x[i] = 0;
    x[0] = 1000;
    load();
    collect(-1);
    check("left0", got[0], nrm(36000));
    check("left1", got[1], nrm(28000));
    check("left7", got[7], nrm(1000));
    check("left8", got[8], 0);
    for (int i = 0; i < N; i++) x[i] = 0;
    x[N-1] = 1000;
    load();
    collect(-1);
    check("right_last", got[N-1], nrm(36000));
    check("right_m8", got[N-8], nrm(1000));
    check("right_m9", got[N-9], 0);
    for (int i = 0; i < N; i++) x[i] = '1;
    load();
    collect(-1);
    check("max_mid", got[N/2], nrm(1023 * 64));
    repeat (2) begin
      for (int i = 0; i < N; i++) x[i] = DW'($urandom);
      load();
      collect(-1);
    end
    for (int i = 0; i < N; i++) x[i] = DW'($urandom);
    load();
    collect(100);
    for (int i = 0; i < N; i++) x[i] = 100;
    load();
    collect(-1);
    check("reload_mid", got[N/2], nrm(6400));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
